tile_map_arbiter: RTL and testbench

TILE_MAP_ARBITER -- requirements
Module: tile_map_arbiter

---
 rtl/tile_map_arbiter_if.sv | 11 +
 rtl/tile_map_arbiter.sv | 77 +++++++
 tb/tb_tile_map_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_map_arbiter_if.sv
// tile_map_arbiter_if: CPU request/response bus into the tile-map arbiter.
interface tile_map_arbiter_if;
   logic        cpu_valid;
   logic        cpu_ready;
   logic        cpu_wen;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   modport master (output cpu_valid, cpu_wen, cpu_addr, cpu_wdata, input cpu_ready, cpu_rdata);
   modport slave (input cpu_valid, cpu_wen, cpu_addr, cpu_wdata, output cpu_ready, cpu_rdata);
endinterface

// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter: shares a 1R1W tile memory between video fetch, CPU accesses and a fill engine.
module tile_map_arbiter #(
   parameter int DEPTH = 2048
) (
   input  logic               clk,
   input  logic               reset,
   tile_map_arbiter_if.slave  cpu,
   input  logic               vid_ren,
   input  logic [11:0]        vid_raddr,
   output logic [7:0]         vid_rdata,
   output logic               mem_ren,
   output logic [11:0]        mem_raddr,
   input  logic [7:0]         mem_rdata,
   output logic               mem_wen,
   output logic [11:0]        mem_waddr,
   output logic [7:0]         mem_wdata
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;
   localparam logic [11:0] LAST = 12'(DEPTH - 1);
   state_t      state, next;
   logic        fill_active, fill_pend, ctl_req, mem_req, cpu_rd, cpu_wr, fill_wr;
   logic [11:0] count, raddr_q, waddr_q;
   logic [7:0]  fill_val, rdata, wdata_q;
   assign vid_rdata = mem_rdata;
   assign cpu.cpu_ready = state == ACK;
   assign cpu.cpu_rdata = rdata;
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= next;
   // reset gates every request so an aborted fill or transaction issues nothing in the reset cycle
   always_comb begin
      ctl_req = state == IDLE && cpu.cpu_valid && cpu.cpu_addr[11] && !reset;
      mem_req = state == IDLE && cpu.cpu_valid && !cpu.cpu_addr[11] && !fill_active && !reset;
      cpu_rd = mem_req && !cpu.cpu_wen && !vid_ren;
      cpu_wr = mem_req && cpu.cpu_wen;
      fill_wr = fill_active && !reset;
      next = state == IDLE ? (cpu_rd ? RD_WAIT : (cpu_wr || ctl_req) ? ACK : IDLE)
           : state == RD_WAIT ? ACK : IDLE;
      mem_ren = vid_ren || cpu_rd;
      mem_raddr = vid_ren ? vid_raddr : cpu_rd ? cpu.cpu_addr : raddr_q;
      mem_wen = fill_wr || cpu_wr;
      mem_waddr = fill_wr ? count : cpu_wr ? cpu.cpu_addr : waddr_q;
      mem_wdata = fill_wr ? fill_val : cpu_wr ? cpu.cpu_wdata : wdata_q;
   end
   always_ff @(posedge clk)
      if (reset) begin
         fill_active <= 1'b0;
         fill_pend <= 1'b0;
         count <= '0;
         fill_val <= '0;
         rdata <= '0;
         raddr_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         if (mem_ren) raddr_q <= mem_raddr;
         if (mem_wen) begin
            waddr_q <= mem_waddr;
            wdata_q <= mem_wdata;
         end
         if (state == RD_WAIT) rdata <= mem_rdata;
         if (ctl_req && !cpu.cpu_wen) rdata <= cpu.cpu_addr == 12'h801 ? {7'b0, fill_active} : 8'h00;
         if (ctl_req && cpu.cpu_wen && cpu.cpu_addr == 12'h800 && !fill_active) begin
            fill_val <= cpu.cpu_wdata;
            fill_pend <= 1'b1;
         end
         // the fill begins the cycle after the control write is acknowledged
         if (state == ACK && fill_pend) begin
            fill_active <= 1'b1;
            fill_pend <= 1'b0;
            count <= '0;
         end else if (fill_active) begin
            if (count == LAST) fill_active <= 1'b0;
            else count <= count + 12'd1;
         end
      end
endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb_tile_map_arbiter: scoreboard bench for the tile-map arbiter with a registered-read memory model.
module tb_tile_map_arbiter;
   localparam int DEPTH = 2048;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vid_ren = 1'b0;
   logic [11:0] vid_raddr = '0;
   logic [7:0]  vid_rdata;
   logic        mem_ren, mem_wen;
   logic [11:0] mem_raddr, mem_waddr;
   logic [7:0]  mem_rdata, mem_wdata;
   logic [7:0]  mem [4096];
   logic [7:0]  ref_mem [4096];
   logic        vid_q = 1'b0;
   logic [19:0] wr_q [$];
   logic [7:0]  rd_q [$];
   logic [7:0]  vd_q [$];
   int          checks = 0;
   int          errors = 0;
   tile_map_arbiter_if cpu ();
   tile_map_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .cpu(cpu),
      .vid_ren(vid_ren), .vid_raddr(vid_raddr), .vid_rdata(vid_rdata),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (mem_wen) mem[mem_waddr] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem[mem_raddr];
      vid_q <= vid_ren;
   end
   always @(negedge clk) begin
      if (mem_wen) begin
         logic [19:0] e;
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL mem_write unexpected: got addr=%h data=%h, none scheduled", mem_waddr, mem_wdata);
         end else begin
            e = wr_q.pop_front();
            if ({mem_waddr, mem_wdata} !== e) begin
               errors++;
               $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h", mem_waddr, mem_wdata, e[19:8], e[7:0]);
            end
         end
      end
      if (vid_q && vd_q.size() != 0) begin
         logic [7:0] e;
         e = vd_q.pop_front();
         checks++;
         if (vid_rdata !== e) begin
            errors++;
            $display("FAIL vid_rdata: got %h expected %h", vid_rdata, e);
         end
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic cpu_op(input logic wen, input logic [11:0] addr, input logic [7:0] wd, input int bound, input bit chk_issue, output int lat);
      logic [7:0] e;
      if (wen && !addr[11]) begin
         wr_q.push_back({addr, wd});
         ref_mem[addr] = wd;
      end
      if (!wen) rd_q.push_back(addr[11] ? (addr == 12'h801 ? {7'b0, dut.fill_active} : 8'h00) : ref_mem[addr]);
      cyc();
      cpu.cpu_valid = 1'b1;
      cpu.cpu_wen = wen;
      cpu.cpu_addr = addr;
      cpu.cpu_wdata = wd;
      #1;
      if (chk_issue) begin
         checks++;
         if (wen ? {mem_wen, mem_waddr, mem_wdata} !== {1'b1, addr, wd} : {mem_ren, mem_raddr} !== {1'b1, addr}) begin
            errors++;
            $display("FAIL issue %h: ren=%b raddr=%h wen=%b waddr=%h wdata=%h, expected access to %h", addr, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, addr);
         end
      end
      lat = 0;
      do begin
         cyc();
         lat++;
      end while (cpu.cpu_ready !== 1'b1 && lat < bound);
      checks++;
      if (cpu.cpu_ready !== 1'b1) begin
         errors++;
         $display("FAIL cpu_ready timeout addr %h: no ready in %0d cycles", addr, bound);
      end
      if (!wen) begin
         e = rd_q.pop_front();
         checks++;
         if (cpu.cpu_rdata !== e) begin
            errors++;
            $display("FAIL cpu_rdata addr %h: got %h expected %h", addr, cpu.cpu_rdata, e);
         end
      end
      cpu.cpu_valid = 1'b0;
   endtask
   task automatic chk_lat(input string name, input int lat, input int exp);
      checks++;
      if (lat !== exp) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp);
      end
   endtask
   task automatic test_reset();
      cpu.cpu_valid = 1'b0;
      cpu.cpu_wen = 1'b0;
      cpu.cpu_addr = '0;
      cpu.cpu_wdata = '0;
      reset = 1'b1;
      cyc();
      cyc();
      checks++;
      if ({cpu.cpu_ready, cpu.cpu_rdata, mem_wen, mem_ren} !== 11'b0) begin
         errors++;
         $display("FAIL reset_state: ready=%b rdata=%h wen=%b ren=%b, expected all 0", cpu.cpu_ready, cpu.cpu_rdata, mem_wen, mem_ren);
      end
      vid_ren = 1'b1;
      vid_raddr = 12'h007;
      #1;
      checks++;
      if ({mem_ren, mem_raddr} !== {1'b1, 12'h007}) begin
         errors++;
         $display("FAIL reset_vid_follow: ren=%b raddr=%h expected 1/007", mem_ren, mem_raddr);
      end
      cyc();
      vid_ren = 1'b0;
      reset = 1'b0;
   endtask
   task automatic test_write_read();
      int lat;
      cpu_op(1'b1, 12'h005, 8'hA5, 10, 1'b1, lat);
      chk_lat("mem_write", lat, 1);
      cpu_op(1'b0, 12'h005, 8'h00, 10, 1'b1, lat);
      chk_lat("mem_read", lat, 2);
   endtask
   task automatic test_vid_priority();
      int lat;
      logic [7:0] e;
      cpu_op(1'b1, 12'h010, 8'h3C, 10, 1'b0, lat);
      for (int i = 0; i < 4; i++) cpu_op(1'b1, 12'h100 + 12'(i), 8'(i * 7 + 1), 10, 1'b0, lat);
      e = ref_mem[12'h010];
      for (int c = 0; c < 7; c++) begin
         cyc();
         vid_ren = c < 4;
         vid_raddr = 12'h100 + 12'(c);
         if (c < 4) vd_q.push_back(ref_mem[12'h100 + 12'(c)]);
         if (c == 0) begin
            cpu.cpu_valid = 1'b1;
            cpu.cpu_wen = 1'b0;
            cpu.cpu_addr = 12'h010;
         end
         #1;
         checks++;
         if (c < 4 && {mem_ren, mem_raddr, cpu.cpu_ready} !== {1'b1, 12'h100 + 12'(c), 1'b0}) begin
            errors++;
            $display("FAIL vid_priority c%0d: ren=%b raddr=%h ready=%b", c, mem_ren, mem_raddr, cpu.cpu_ready);
         end else if (c == 4 && {mem_ren, mem_raddr, cpu.cpu_ready} !== {1'b1, 12'h010, 1'b0}) begin
            errors++;
            $display("FAIL vid_release_issue: ren=%b raddr=%h ready=%b expected 1/010/0", mem_ren, mem_raddr, cpu.cpu_ready);
         end else if (c == 5 && {mem_ren, cpu.cpu_ready} !== 2'b00) begin
            errors++;
            $display("FAIL vid_rd_wait: ren=%b ready=%b expected 0/0", mem_ren, cpu.cpu_ready);
         end else if (c == 6 && {cpu.cpu_ready, cpu.cpu_rdata} !== {1'b1, e}) begin
            errors++;
            $display("FAIL vid_cpu_done: ready=%b rdata=%h expected 1/%h", cpu.cpu_ready, cpu.cpu_rdata, e);
         end
      end
      cpu.cpu_valid = 1'b0;
   endtask
   task automatic test_ctrl();
      int lat;
      cpu_op(1'b0, 12'h801, 8'h00, 10, 1'b0, lat);
      chk_lat("status_read", lat, 1);
      cpu_op(1'b0, 12'h8FF, 8'h00, 10, 1'b0, lat);
      chk_lat("ctrl_other_read", lat, 1);
      cpu_op(1'b1, 12'h8AB, 8'hFF, 10, 1'b0, lat);
      chk_lat("ctrl_other_write", lat, 1);
      vid_ren = 1'b1;
      vid_raddr = 12'h005;
      cpu_op(1'b0, 12'h801, 8'h00, 10, 1'b0, lat);
      chk_lat("status_with_vid", lat, 1);
      vid_ren = 1'b0;
   endtask
   task automatic start_fill(input logic [7:0] v, input int n);
      int lat;
      for (int i = 0; i < n; i++) begin
         wr_q.push_back({12'(i), v});
         ref_mem[i] = v;
      end
      cpu_op(1'b1, 12'h800, v, 10, 1'b0, lat);
      chk_lat("fill_start", lat, 1);
   endtask
   task automatic test_fill();
      int lat, n;
      start_fill(8'h20, DEPTH);
      checks++;
      if (mem_wen !== 1'b0) begin
         errors++;
         $display("FAIL fill_ack_cycle: mem_wen=%b expected 0", mem_wen);
      end
      cyc();
      checks++;
      if ({mem_wen, mem_waddr, mem_wdata} !== {1'b1, 12'h000, 8'h20}) begin
         errors++;
         $display("FAIL fill_first: wen=%b addr=%h data=%h expected 1/000/20", mem_wen, mem_waddr, mem_wdata);
      end
      cpu_op(1'b0, 12'h801, 8'h00, 10, 1'b0, lat);
      checks++;
      if (cpu.cpu_rdata !== 8'h01) begin
         errors++;
         $display("FAIL status_during_fill: got %h expected 01", cpu.cpu_rdata);
      end
      cpu_op(1'b1, 12'h800, 8'h77, 10, 1'b0, lat);
      chk_lat("fill_ignored_ack", lat, 1);
      n = 0;
      while (wr_q.size() != 0 && n < DEPTH + 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("FAIL fill_complete: %0d writes outstanding, expected 0", wr_q.size());
      end
      cyc();
      checks++;
      if (mem_wen !== 1'b0) begin
         errors++;
         $display("FAIL fill_end: mem_wen=%b after last address, expected 0", mem_wen);
      end
      cpu_op(1'b0, 12'h801, 8'h00, 10, 1'b0, lat);
      checks++;
      if (cpu.cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL status_after_fill: got %h expected 00", cpu.cpu_rdata);
      end
   endtask
   task automatic test_write_during_fill();
      int lat;
      start_fill(8'h33, DEPTH);
      cpu_op(1'b1, 12'h040, 8'hC7, DEPTH + 100, 1'b0, lat);
      chk_lat("write_stalled_by_fill", lat, DEPTH + 1);
      cpu_op(1'b0, 12'h040, 8'h00, 10, 1'b0, lat);
      cpu_op(1'b0, 12'h041, 8'h00, 10, 1'b0, lat);
   endtask
   task automatic test_reset_mid_fill();
      int lat, n, bad;
      start_fill(8'h55, 100);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!(mem_wen === 1'b1 && mem_waddr === 12'd100) && n < 300);
      reset = 1'b1;
      #1;
      checks++;
      if ({mem_wen, 32'(wr_q.size())} !== 33'b0) begin
         errors++;
         $display("FAIL reset_mid_fill: wen=%b outstanding=%0d expected 0/0", mem_wen, wr_q.size());
      end
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      checks++;
      if (mem_wen !== 1'b0) begin
         errors++;
         $display("FAIL fill_aborted: mem_wen=%b expected 0", mem_wen);
      end
      cpu_op(1'b0, 12'h801, 8'h00, 10, 1'b0, lat);
      checks++;
      if (cpu.cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL status_after_abort: got %h expected 00", cpu.cpu_rdata);
      end
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL memory_contents: %0d locations differ, expected 0", bad);
      end
      cpu_op(1'b0, 12'd100, 8'h00, 10, 1'b0, lat);
      cpu_op(1'b0, 12'd99, 8'h00, 10, 1'b0, lat);
   endtask
   task automatic test_reset_txn();
      cyc();
      cpu.cpu_valid = 1'b1;
      cpu.cpu_wen = 1'b0;
      cpu.cpu_addr = 12'h005;
      cyc();
      reset = 1'b1;
      cpu.cpu_valid = 1'b0;
      cyc();
      checks++;
      if ({cpu.cpu_ready, cpu.cpu_rdata} !== 9'b0) begin
         errors++;
         $display("FAIL reset_txn: ready=%b rdata=%h expected 0/00", cpu.cpu_ready, cpu.cpu_rdata);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (cpu.cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_txn_dropped cycle %0d: ready=%b expected 0", i, cpu.cpu_ready);
         end
      end
   endtask
   initial begin
      test_reset();
      test_write_read();
      test_vid_priority();
      test_ctrl();
      test_fill();
      test_write_during_fill();
      test_reset_mid_fill();
      test_reset_txn();
      repeat (2) cyc();
      checks++;
      if (wr_q.size() + rd_q.size() + vd_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: wr=%0d rd=%0d vid=%0d left, expected 0", wr_q.size(), rd_q.size(), vd_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
